// File: rtl/big_core_kbd_ps2_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches kbd_clk/kbd_data, deserialises 11-bit frames into {parity, data}.
// Optional mid-frame timeout abort is enabled by defining MAFIA_KBD_RX_TIMEOUT_EN.
module big_core_kbd_ps2_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    output logic       rx_valid,
    output logic [8:0] rx_data,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

    state_t     r_state, w_state_next;
    logic [1:0] r_clk_sync, r_data_sync;
    logic       w_clk_s, w_data_s;
    logic [3:0] r_filt_cnt;
    logic       r_filt_lvl, r_filt_lvl_d, r_fe;
    logic [3:0] r_cnt, w_cnt_next;
    logic [8:0] r_shift, w_shift_next;
    logic [8:0] r_rx_data, w_rx_data_next;
    logic       r_rx_valid, w_rx_valid_next;
    logic       r_frame_err, w_frame_err_next;
    logic       w_timeout;

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], kbd_clk};
            r_data_sync <= {r_data_sync[0], kbd_data};
        end
    end

    // Level only flips after FILTER_LEN consecutive cycles at the new value;
    // the edge strobe comes one cycle later via the delayed level copy.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_filt_cnt   <= 4'd0;
            r_filt_lvl   <= 1'b1;
            r_filt_lvl_d <= 1'b1;
            r_fe         <= 1'b0;
        end else begin
            r_filt_lvl_d <= r_filt_lvl;
            r_fe         <= r_filt_lvl_d & ~r_filt_lvl;
            if (w_clk_s != r_filt_lvl) begin
                if (r_filt_cnt == FILT_LAST) begin
                    r_filt_lvl <= ~r_filt_lvl;
                    r_filt_cnt <= 4'd0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 4'd1;
                end
            end else begin
                r_filt_cnt <= 4'd0;
            end
        end
    end

`ifdef MAFIA_KBD_RX_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_idle_cnt;

    assign w_timeout = (r_state != S_IDLE) && (r_idle_cnt == TO_LAST);

    always_ff @(posedge Clk) begin
        if (Rst || r_state == S_IDLE || r_fe || w_timeout) begin
            r_idle_cnt <= 16'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_shift     <= 9'd0;
            r_rx_data   <= 9'd0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_shift     <= w_shift_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_valid  <= w_rx_valid_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_shift_next     = r_shift;
        w_rx_data_next   = r_rx_data;
        w_rx_valid_next  = 1'b0;
        w_frame_err_next = 1'b0;
        if (w_timeout) begin
            w_state_next     = S_IDLE;
            w_frame_err_next = 1'b1;
        end else if (r_fe) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_data_s) begin
                        w_state_next = S_DATA;
                        w_cnt_next   = 4'd0;
                    end
                end
                S_DATA: begin
                    // Bit 8 of the shift register captures the parity bit.
                    w_shift_next[r_cnt] = w_data_s;
                    w_cnt_next          = r_cnt + 4'd1;
                    if (r_cnt == 4'd8) begin
                        w_state_next = S_STOP;
                    end
                end
                S_STOP: begin
                    w_state_next = S_IDLE;
                    if (w_data_s) begin
                        w_rx_valid_next = 1'b1;
                        w_rx_data_next  = r_shift;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_big_core_kbd_ps2_rx.sv
// Scoreboard bench for the PS/2 receiver: frames are driven bit by bit, expected words queued, checked at the output pulse.
module tb_big_core_kbd_ps2_rx;

    localparam int FILTER_LEN = 4;
    localparam int HALF       = 20;

    typedef struct packed {
        logic       err;
        logic [8:0] data;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       kbd_clk = 1'b1;
    logic       kbd_data = 1'b1;
    logic       rx_valid;
    logic [8:0] rx_data;
    logic       frame_err;
    logic       rx_busy;

    exp_t       q[$];
    logic [8:0] last_data = 9'd0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       prev_pulse = 1'b0;

    big_core_kbd_ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(50000)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .kbd_clk  (kbd_clk),
        .kbd_data (kbd_data),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Rst) begin
            if (rx_valid && frame_err) check_val("excl", 1, 0);
            if (prev_pulse && (rx_valid || frame_err)) check_val("pulse_width", 2, 1);
            if (rx_valid || frame_err) begin
                if (q.size() == 0) begin
                    check_val("unexpected", {rx_valid, frame_err}, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("rx: valid=%0b err=%0b data=%03h (exp err=%0b data=%03h)",
                             rx_valid, frame_err, rx_data, e.err, e.data);
                    check_val("kind", {31'd0, frame_err}, {31'd0, e.err});
                    check_val("data", {23'd0, rx_data}, {23'd0, e.data});
                end
            end
            prev_pulse <= rx_valid | frame_err;
        end else begin
            prev_pulse <= 1'b0;
        end
    end

    // Drives one PS/2 bit; optionally measures output latency from the falling edge.
    task automatic ps2_bit(input logic b, input bit meas);
        int lat;
        kbd_data = b;
        repeat (HALF) @(posedge Clk);
        #1 kbd_clk = 1'b0;
        if (meas) begin
            lat = -1;
            for (int k = 0; k < HALF; k++) begin
                @(posedge Clk);
                #1;
                if (lat < 0 && (rx_valid || frame_err)) lat = k;
            end
            check_val("latency", lat, FILTER_LEN + 3);
        end else begin
            repeat (HALF) @(posedge Clk);
            #1;
        end
        kbd_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        exp_t e;
        ps2_bit(1'b0, 1'b0);
        check_val("busy_mid", {31'd0, rx_busy}, 1);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
        ps2_bit(p, 1'b0);
        if (s) begin
            last_data = {p, d};
            e.err = 1'b0;
        end else begin
            e.err = 1'b1;
        end
        e.data = last_data;
        q.push_back(e);
        ps2_bit(s, 1'b1);
        check_val("busy_end", {31'd0, rx_busy}, 0);
        check_val("q_drained", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        check_val("rst_valid", {31'd0, rx_valid}, 0);
        check_val("rst_data", {23'd0, rx_data}, 0);
        check_val("rst_err", {31'd0, frame_err}, 0);
        check_val("rst_busy", {31'd0, rx_busy}, 0);
        repeat (10) @(posedge Clk);

        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0);
        check_val("held_data", {23'd0, rx_data}, {23'd0, last_data});

        // Short low glitch on kbd_clk with data low must not start a frame.
        kbd_data = 1'b0;
        @(posedge Clk);
        #1 kbd_clk = 1'b0;
        repeat (2) @(posedge Clk);
        #1 kbd_clk = 1'b1;
        repeat (20) @(posedge Clk);
        #1 check_val("glitch_busy", {31'd0, rx_busy}, 0);
        kbd_data = 1'b1;

        // Partial frame aborted by reset.
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 1'b0);
        @(posedge Clk);
        #1 Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        last_data = 9'd0;
        kbd_data = 1'b1;
        check_val("rst2_busy", {31'd0, rx_busy}, 0);
        check_val("rst2_data", {23'd0, rx_data}, 0);
        repeat (10) @(posedge Clk);
        send_frame(8'h1C, 1'b0, 1'b1);

        for (int n = 0; n < 4; n++) begin
            logic [7:0] rb;
            logic       rp;
            rb = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            send_frame(rb, rp, 1'b1);
        end

        repeat (50) @(posedge Clk);
        #1 check_val("final_q", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
